// File: rtl/mem_stage_sequencer_pkg.sv
// Shared MEM-stage definitions: sequencer states, op encodings and the strobe decode.
// Pure declarations, no latency; no backpressure.
package mem_pkg;

  localparam logic [1:0]  MEM_NONE           = 2'b00;
  localparam logic [1:0]  MEM_WORD           = 2'b01;
  localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

  typedef enum logic [3:0] {
    IDLE,
    RAM_RD,
    RAM_WR_SETUP,
    RAM_WR_PULSE,
    RAM_WR_HOLD,
    UART_RD,
    UART_WR_SETUP,
    UART_WR_PULSE,
    UART_WR_WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic ram1EN;
    logic ram1OE;
    logic ram1WE;
    logic rdn;
    logic wrn;
    logic busDrive;
  } strobe_t;

  // Active-low strobes plus the bus-drive flag, as a pure function of state.
  function automatic strobe_t strobes_of(state_t s);
    strobe_t o;
    o.ram1EN   = !(s inside {RAM_RD, RAM_WR_SETUP, RAM_WR_PULSE, RAM_WR_HOLD});
    o.ram1OE   = (s != RAM_RD);
    o.ram1WE   = (s != RAM_WR_PULSE);
    o.rdn      = (s != UART_RD);
    o.wrn      = (s != UART_WR_PULSE);
    o.busDrive = (s inside {RAM_WR_SETUP, RAM_WR_PULSE, RAM_WR_HOLD,
                            UART_WR_SETUP, UART_WR_PULSE});
    return o;
  endfunction

endpackage

// File: rtl/mem_stage_sequencer_if.sv
// EX/MEM request bundle and MEM/WB load result with the pipeline stall/done handshake.
// No latency of its own; stall is the only backpressure toward the pipeline.
interface mem_stage_sequencer_if;
  import mem_pkg::*;

  logic [1:0]  memRead;
  logic [1:0]  memWrite;
  logic [15:0] address;
  logic [15:0] dataIn;
  logic [15:0] dataOut;
  logic        stall;
  logic        done;

  modport master (output memRead, memWrite, address, dataIn,
                  input  dataOut, stall, done);
  modport slave  (input  memRead, memWrite, address, dataIn,
                  output dataOut, stall, done);
endinterface

// File: rtl/mem_stage_sequencer.sv
// Sequences one MEM-stage load/store onto RAM1 or the serial port; 2..(3+UART_PULSE+wait) cycles.
// Holds stall high from the request cycle until DONE; the pipeline advances on the edge ending DONE.
module mem_stage_sequencer
  import mem_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
  parameter int          UART_PULSE     = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  mem_stage_sequencer_if.slave  pipe,
  output logic                  ram1OE,
  output logic                  ram1WE,
  output logic                  ram1EN,
  output logic [17:0]           ram1Addr,
  inout  wire  [15:0]           ram1Data,
  input  logic                  data_ready,
  input  logic                  tbre,
  input  logic                  tsre,
  output logic                  rdn,
  output logic                  wrn
);

  localparam int            CW       = $clog2(UART_PULSE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(UART_PULSE - 1);

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   addr_q;
  logic [15:0]   data_q;
  logic [CW-1:0] cnt;
  logic          busDrive;
  logic          busy_q;
  logic          store;
  logic          load;
  logic          req;
  logic          tgt_data;
  logic          tgt_stat;
  logic          pulse_last;

  // Store wins when both op fields request an access.
  assign store      = (pipe.memWrite == MEM_WORD);
  assign load       = (pipe.memRead == MEM_WORD) && !store;
  assign req        = load || store;
  assign tgt_data   = (pipe.address == UART_DATA_ADDR);
  assign tgt_stat   = (pipe.address == UART_STAT_ADDR);
  assign pulse_last = (cnt == CNT_LAST);

  assign pipe.stall = busy_q || (state == IDLE && req);
  assign ram1Addr   = {2'b00, addr_q};
  assign ram1Data   = busDrive ? data_q : 16'hzzzz;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (tgt_stat)      state_nxt = DONE;
          else if (tgt_data) state_nxt = store ? UART_WR_SETUP : UART_RD;
          else               state_nxt = store ? RAM_WR_SETUP : RAM_RD;
        end
      end
      RAM_RD:        state_nxt = DONE;
      RAM_WR_SETUP:  state_nxt = RAM_WR_PULSE;
      RAM_WR_PULSE:  state_nxt = RAM_WR_HOLD;
      RAM_WR_HOLD:   state_nxt = DONE;
      UART_RD:       if (pulse_last) state_nxt = DONE;
      UART_WR_SETUP: state_nxt = UART_WR_PULSE;
      UART_WR_PULSE: if (pulse_last) state_nxt = UART_WR_WAIT;
      UART_WR_WAIT:  if (tbre && tsre) state_nxt = DONE;
      DONE:          state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they track the state register exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      cnt          <= '0;
      busy_q       <= 1'b0;
      pipe.done    <= 1'b0;
      pipe.dataOut <= '0;
      {ram1EN, ram1OE, ram1WE, rdn, wrn, busDrive} <= strobes_of(IDLE);
    end else begin
      state     <= state_nxt;
      busy_q    <= (state_nxt != IDLE) && (state_nxt != DONE);
      pipe.done <= (state_nxt == DONE);
      {ram1EN, ram1OE, ram1WE, rdn, wrn, busDrive} <= strobes_of(state_nxt);

      if (state == IDLE && req) begin
        addr_q <= pipe.address;
        data_q <= pipe.dataIn;
      end

      if (state_nxt != state)
        cnt <= '0;
      else if (state == UART_RD || state == UART_WR_PULSE)
        cnt <= cnt + 1'b1;

      if (state == IDLE && load && tgt_stat)
        pipe.dataOut <= {14'b0, data_ready, tbre & tsre};
      else if (state == RAM_RD)
        pipe.dataOut <= ram1Data;
      else if (state == UART_RD && state_nxt == DONE)
        pipe.dataOut <= {8'h00, ram1Data[7:0]};
    end
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed bench for mem_stage_sequencer: scoreboard of expected completion cycle and load data,
// plus per-access strobe/stall tallies from a negedge sampler.
module tb_mem_stage_sequencer;
  import mem_pkg::*;

  localparam int P = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ram1OE, ram1WE, ram1EN, rdn, wrn;
  logic        data_ready, tbre, tsre;
  logic [17:0] ram1Addr;
  wire  [15:0] ram1Data;

  logic        probe_drv;
  logic [15:0] probe_val;
  logic [15:0] uart_rx;
  logic [15:0] ram_mem [0:255];

  always #5 CLK = ~CLK;

  mem_stage_sequencer_if bus ();

  mem_stage_sequencer #(.UART_PULSE(P)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pipe       (bus),
    .ram1OE     (ram1OE),
    .ram1WE     (ram1WE),
    .ram1EN     (ram1EN),
    .ram1Addr   (ram1Addr),
    .ram1Data   (ram1Data),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .rdn        (rdn),
    .wrn        (wrn)
  );

  // RAM1 and UART device models sharing the bus.
  assign ram1Data = (!ram1EN && !ram1OE) ? ram_mem[ram1Addr[7:0]] :
                    (!rdn ? uart_rx : (probe_drv ? probe_val : 16'hzzzz));

  always @(posedge CLK)
    if (!ram1EN && !ram1WE) ram_mem[ram1Addr[7:0]] <= ram1Data;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: each access pushes the cycle its done pulse must appear in and the dataOut then.
  typedef struct {
    int unsigned done_cyc;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge CLK) begin
    if (!RST && bus.done) begin
      chk("done with pending entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done cycle", cyc, e.done_cyc);
        chk("dataOut", {16'h0, bus.dataOut}, {16'h0, e.data});
      end
    end
  end

  // Monotonic strobe tallies; the stimulus diffs them around each access.
  typedef struct packed {
    int we, oe, rd, wr, en, stall, bad, done;
  } tally_t;
  tally_t      t = '0;
  logic [17:0] we_addr = '0;
  int unsigned oe_cyc = 0;
  logic [15:0] exp_bus = '0;

  always @(negedge CLK) begin
    if (ram1WE === 1'b0) begin t.we <= t.we + 1; we_addr <= ram1Addr; end
    if ((ram1WE === 1'b0 || wrn === 1'b0) && ram1Data !== exp_bus) t.bad <= t.bad + 1;
    if (ram1OE === 1'b0) begin t.oe <= t.oe + 1; oe_cyc <= cyc; end
    if (rdn === 1'b0)       t.rd    <= t.rd + 1;
    if (wrn === 1'b0)       t.wr    <= t.wr + 1;
    if (ram1EN === 1'b0)    t.en    <= t.en + 1;
    if (bus.stall === 1'b1) t.stall <= t.stall + 1;
    if (bus.done === 1'b1)  t.done  <= t.done + 1;
  end

  task automatic idle_inputs();
    bus.memRead  = MEM_NONE;
    bus.memWrite = MEM_NONE;
    bus.address  = 16'h0000;
    bus.dataIn   = 16'h0000;
  endtask

  task automatic issue(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [15:0] a, input logic [15:0] d);
    bus.memRead  = rd;
    bus.memWrite = wr;
    bus.address  = a;
    bus.dataIn   = d;
  endtask

  // Waits for done, then drops the op on the edge that ends DONE (pipeline advance).
  task automatic wait_done(input string name, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge CLK);
      seen = bus.done;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, max_cyc);
    end
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  tally_t      b;
  int unsigned k;

  initial begin
    RST        = 1'b1;
    probe_drv  = 1'b0;
    probe_val  = 16'h0000;
    uart_rx    = 16'h0000;
    data_ready = 1'b0;
    tbre       = 1'b1;
    tsre       = 1'b1;
    for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
    idle_inputs();

    repeat (2) @(posedge CLK);
    #1;
    chk("reset stall",    {31'h0, bus.stall}, 32'd0);
    chk("reset done",     {31'h0, bus.done},  32'd0);
    chk("reset dataOut",  {16'h0, bus.dataOut}, 32'h0);
    chk("reset strobes",  {27'h0, ram1OE, ram1WE, ram1EN, rdn, wrn}, 32'h1F);
    chk("reset ram1Addr", {14'h0, ram1Addr}, 32'h0);
    probe_drv = 1'b1; probe_val = 16'h1234;
    #1;
    chk("reset bus released", {16'h0, ram1Data}, 32'h1234);
    probe_drv = 1'b0;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // RAM store
    b = t; k = cyc; exp_bus = 16'hBEEF;
    issue(MEM_NONE, MEM_WORD, 16'h4000, 16'hBEEF);
    exp_q.push_back('{k + 4, 16'h0000});
    wait_done("ram store", 20);
    chk("ram store WE cycles", t.we - b.we, 1);
    chk("ram store bus at WE", t.bad - b.bad, 0);
    chk("ram store stall cycles", t.stall - b.stall, 4);
    chk("ram store ram1Addr", {14'h0, we_addr}, 32'h04000);
    chk("ram store uart strobes", (t.rd - b.rd) + (t.wr - b.wr) + (t.oe - b.oe), 0);

    // RAM load of the stored word
    b = t; k = cyc;
    issue(MEM_WORD, MEM_NONE, 16'h4000, 16'h0000);
    exp_q.push_back('{k + 2, 16'hBEEF});
    wait_done("ram load", 20);
    chk("ram load OE cycles", t.oe - b.oe, 1);
    chk("ram load OE cycle", oe_cyc, k + 1);
    chk("ram load WE cycles", t.we - b.we, 0);
    chk("ram load stall cycles", t.stall - b.stall, 2);

    // UART store; tsre held low for 6 cycles from the request
    tbre = 1'b1; tsre = 1'b0;
    b = t; k = cyc; exp_bus = 16'h0041;
    issue(MEM_NONE, MEM_WORD, 16'hBF00, 16'h0041);
    exp_q.push_back('{k + 7, 16'hBEEF});
    repeat (6) @(posedge CLK);
    #1;
    tsre = 1'b1;
    wait_done("uart store", 20);
    chk("uart store wrn cycles", t.wr - b.wr, P);
    chk("uart store bus at wrn", t.bad - b.bad, 0);
    chk("uart store stall cycles", t.stall - b.stall, 7);
    chk("uart store ram1EN cycles", t.en - b.en, 0);

    // UART load: upper byte of the bus is discarded
    uart_rx = 16'hFF5A;
    b = t; k = cyc;
    issue(MEM_WORD, MEM_NONE, 16'hBF00, 16'h0000);
    exp_q.push_back('{k + 2 + P - 1, 16'h005A});
    wait_done("uart load", 20);
    chk("uart load rdn cycles", t.rd - b.rd, P);
    chk("uart load stall cycles", t.stall - b.stall, 1 + P);

    // Status load
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
    b = t; k = cyc;
    issue(MEM_WORD, MEM_NONE, 16'hBF01, 16'h0000);
    exp_q.push_back('{k + 1, 16'h0002});
    wait_done("status load", 20);
    chk("status strobes", (t.we - b.we) + (t.oe - b.oe) + (t.en - b.en) +
                          (t.rd - b.rd) + (t.wr - b.wr), 0);
    chk("status stall cycles", t.stall - b.stall, 1);

    // Status store: no side effect, dataOut held
    b = t; k = cyc;
    issue(MEM_NONE, MEM_WORD, 16'hBF01, 16'h5555);
    exp_q.push_back('{k + 1, 16'h0002});
    wait_done("status store", 20);
    chk("status store strobes", (t.we - b.we) + (t.wr - b.wr) + (t.en - b.en), 0);

    // Both load and store requested: store wins
    b = t; k = cyc; exp_bus = 16'h1234;
    issue(MEM_WORD, MEM_WORD, 16'h4010, 16'h1234);
    exp_q.push_back('{k + 4, 16'h0002});
    wait_done("load+store", 20);
    chk("load+store WE cycles", t.we - b.we, 1);
    chk("load+store OE cycles", t.oe - b.oe, 0);
    chk("load+store bus at WE", t.bad - b.bad, 0);

    // Reset during RAM_WR_PULSE
    b = t; k = cyc; exp_bus = 16'hCAFE;
    issue(MEM_NONE, MEM_WORD, 16'h4020, 16'hCAFE);
    repeat (2) @(posedge CLK);
    #1;
    chk("abort reaches WE pulse", {31'h0, ram1WE}, 32'd0);
    RST = 1'b1;
    idle_inputs();
    @(posedge CLK);
    #1;
    chk("abort WE", {31'h0, ram1WE}, 32'd1);
    chk("abort EN", {31'h0, ram1EN}, 32'd1);
    chk("abort stall", {31'h0, bus.stall}, 32'd0);
    probe_drv = 1'b1; probe_val = 16'h1234;
    #1;
    chk("abort bus released", {16'h0, ram1Data}, 32'h1234);
    probe_drv = 1'b0;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("abort done pulses", t.done - b.done, 0);

    // Normal load after the abort
    b = t; k = cyc;
    issue(MEM_WORD, MEM_NONE, 16'h4000, 16'h0000);
    exp_q.push_back('{k + 2, 16'hBEEF});
    wait_done("load after abort", 20);
    chk("load after abort OE cycle", oe_cyc, k + 1);

    repeat (2) @(posedge CLK);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
